text_screen_buffer: RTL and testbench
=====================================

// Module: text_screen_buffer
// PURPOSE
//  Text-mode character store feeding the 640x480 VGA text renderer, sitting directly upstream of it.
//  Holds one 8-bit character plus a 3-bit fg and a 3-bit bg colour per cell, 80x60 cells.
//  Answers the renderer's characterPos lookup with zero latency.
//  Accepts a CPU/UART byte stream via valid/ready: prints characters, handles control codes and hardware scroll.
// PARAMETERS
//  COLS        80      columns on screen (<=128)
//  ROWS        60      rows on screen (<=64)
//  DEFAULT_FG  3'b111  fg colour used by clears and out-of-range reads
//  DEFAULT_BG  3'b000  bg colour used by clears and out-of-range reads
// PORTS
//  clk           in   1   pixel clock, same domain as the renderer; one clock only
//  reset         in   1   synchronous, active-high
//  wrValid       in   1   byte offered on wrData
//  wrData        in   8   character or control code
//  wrFg          in   3   fg colour for a printable byte
//  wrBg          in   3   bg colour for a printable byte
//  wrReady       out  1   block can accept a byte this cycle
//  characterPos  in   13  [12:6] column, [5:0] row, from the renderer
//  character     out  8   character at characterPos (combinational)
//  fgColor       out  3   fg colour at characterPos (combinational)
//  bgColor       out  3   bg colour at characterPos (combinational)
//  cursorCol     out  7   current logical cursor column
//  cursorRow     out  6   current logical cursor row
//  busy          out  1   clear in progress (== !wrReady)
// BEHAVIOUR
//  Reset:
//   - cursorCol=0, cursorRow=0, scrollBase=0.
//   - State goes to CLEAR_ALL; wrReady=0 and busy=1 from the first cycle after reset.
//  States and exits:
//   - IDLE
//   - CLEAR_ROW: exactly COLS cycles, then IDLE.
//   - CLEAR_ALL: exactly COLS*ROWS cycles, then IDLE.
//   - In both clear states, every cleared cell = 0x20 with DEFAULT_FG/DEFAULT_BG.
//   - wrReady=1 only in IDLE. It rises the cycle after the last clear write.
//  Handshake: a byte transfers on a posedge with wrValid&&wrReady; at most one byte per cycle.
//  Physical row of a logical row r: p = r+scrollBase, minus ROWS if >= ROWS (no divider).
//  Printable byte 0x20..0x7F:
//   - Written to (cursorCol, phys(cursorRow)) with wrFg/wrBg.
//   - If cursorCol < COLS-1: cursorCol+1. Otherwise cursorCol=0 and NEWLINE.
//  Control codes:
//   - 0x0D: cursorCol=0.
//   - 0x0A: NEWLINE.
//   - 0x08: cursorCol-1 if >0, else no effect; no erase.
//   - 0x0C: cursor=(0,0), scrollBase=0, then CLEAR_ALL.
//   - Every other byte (<0x20, >=0x80): accepted, no effect.
//  NEWLINE:
//   - If cursorRow < ROWS-1: cursorRow+1.
//   - Otherwise cursorRow stays ROWS-1, scrollBase+1 (wraps ROWS-1 -> 0).
//     The old scrollBase physical row is then cleared via CLEAR_ROW.
//  Read path (combinational, same cycle):
//   - col=characterPos[12:6], row=characterPos[5:0].
//   - If col>=COLS or row>=ROWS: outputs 0x20/DEFAULT_FG/DEFAULT_BG.
//   - Otherwise: memory[phys(row)][col].
//   - Reads during a clear show whatever memory holds; partial clears are visible.
//  Reset mid-operation:
//   - Any state aborts. Cursor and scrollBase zero, full CLEAR_ALL restarts from cell 0.
//   - No pending byte is retained.
//  Cursor outputs change the cycle after the accepting edge.
// TESTING
//  1. Pulse reset, count cycles: wrReady low for exactly 4800 cycles. Then any in-range position -> 0x20, fg 7, bg 0.
//  2. Send 0x41, fg=2, bg=1 -> characterPos {col0,row0} gives 0x41/2/1; cursor=(1,0). Then send 0x08 -> cursor (0,0), cell still 0x41.
//  3. Send 80 bytes 0x30..0x7F -> cursor=(0,1); cell (79,0)=0x7F. Send 0x0D mid-row -> cursorCol=0, row unchanged.
//  4. Fill rows 0..59 with row index+0x30, then send 0x0A -> wrReady low 80 cycles.
//     Then row 0 reads 0x31, row 58 reads 0x6B, row 59 reads 0x20 x80; cursorRow stays 59.
//  5. Read characterPos col 85 row 10 and col 3 row 61 -> 0x20/7/0. Send 0x07 -> accepted in one cycle, nothing changes.
//  6. Assert reset during a CLEAR_ROW -> cursor (0,0), wrReady low 4800 cycles, whole screen 0x20.
//     Send 0x0C on a full screen -> same result.

Source files
------------

// File: rtl/text_screen_buffer_if.sv
// Byte-stream write port and renderer lookup port of the text screen buffer.
// The master side is the CPU/UART writer plus the renderer; the slave side is the buffer.
interface text_screen_buffer_if;
  logic        wrValid;
  logic [7:0]  wrData;
  logic [2:0]  wrFg;
  logic [2:0]  wrBg;
  logic        wrReady;
  logic [12:0] characterPos;
  logic [7:0]  character;
  logic [2:0]  fgColor;
  logic [2:0]  bgColor;
  logic [6:0]  cursorCol;
  logic [5:0]  cursorRow;
  logic        busy;

  modport master (
    output wrValid, wrData, wrFg, wrBg, characterPos,
    input  wrReady, character, fgColor, bgColor, cursorCol, cursorRow, busy
  );

  modport slave (
    input  wrValid, wrData, wrFg, wrBg, characterPos,
    output wrReady, character, fgColor, bgColor, cursorCol, cursorRow, busy
  );
endinterface

// File: rtl/text_screen_buffer.sv
// 80x60 text-mode character store: byte-stream writer with cursor, control codes and
// hardware scroll, plus a zero-latency lookup port for the VGA text renderer.
module text_screen_buffer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 60,
  parameter logic [2:0] DEFAULT_FG = 3'b111,
  parameter logic [2:0] DEFAULT_BG = 3'b000
) (
  input logic                clk,
  input logic                reset,
  text_screen_buffer_if.slave bus
);

  localparam int          CELLS     = COLS * ROWS;
  localparam logic [12:0] LAST_CELL = 13'(CELLS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
  localparam logic [13:0] BLANK     = {8'h20, DEFAULT_FG, DEFAULT_BG};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ROW = 2'd1,
    CLEAR_ALL = 2'd2
  } state_t;

  state_t      state;
  state_t      nextState;
  logic [12:0] clearCnt;
  logic [5:0]  clearRow;
  logic [6:0]  cursorCol;
  logic [5:0]  cursorRow;
  logic [5:0]  scrollBase;
  logic [13:0] mem [CELLS];

  logic        accept;
  logic        isPrint;
  logic        isFormFeed;
  logic        doNewline;
  logic        needScroll;
  logic        memWe;
  logic [12:0] memAddr;
  logic [13:0] memData;
  logic [6:0]  rdCol;
  logic [5:0]  rdRow;
  logic [13:0] rdCell;

  // Logical row to physical row via a single conditional subtract instead of a modulo.
  function automatic logic [5:0] physRow(input logic [5:0] row, input logic [5:0] base);
    logic [6:0] sum;
    sum = {1'b0, row} + {1'b0, base};
    if (sum >= 7'(ROWS)) begin
      sum = sum - 7'(ROWS);
    end else begin
      sum = sum;
    end
    return sum[5:0];
  endfunction

  function automatic logic [12:0] cellAddr(input logic [5:0] row, input logic [6:0] col);
    return 13'(13'(row) * 13'(COLS) + 13'(col));
  endfunction

  assign accept     = bus.wrValid && (state == IDLE);
  assign isPrint    = (bus.wrData[7] == 1'b0) && (bus.wrData >= 8'h20);
  assign isFormFeed = (bus.wrData == 8'h0C);
  assign doNewline  = (isPrint && (cursorCol == LAST_COL)) || (bus.wrData == 8'h0A);
  assign needScroll = doNewline && (cursorRow == LAST_ROW);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ALL;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept && isFormFeed) begin
          nextState = CLEAR_ALL;
        end else if (accept && needScroll) begin
          nextState = CLEAR_ROW;
        end else begin
          nextState = IDLE;
        end
      end
      CLEAR_ROW: begin
        if (clearCnt == {6'd0, LAST_COL}) begin
          nextState = IDLE;
        end else begin
          nextState = CLEAR_ROW;
        end
      end
      CLEAR_ALL: begin
        if (clearCnt == LAST_CELL) begin
          nextState = IDLE;
        end else begin
          nextState = CLEAR_ALL;
        end
      end
      default: nextState = CLEAR_ALL;
    endcase
  end

  // Output logic: handshake and the single memory write port.
  always_comb begin
    memWe   = 1'b0;
    memAddr = 13'd0;
    memData = BLANK;
    case (state)
      IDLE: begin
        if (accept && isPrint) begin
          memWe   = 1'b1;
          memAddr = cellAddr(physRow(cursorRow, scrollBase), cursorCol);
          memData = {bus.wrData, bus.wrFg, bus.wrBg};
        end else begin
          memWe = 1'b0;
        end
      end
      CLEAR_ROW: begin
        memWe   = 1'b1;
        memAddr = cellAddr(clearRow, clearCnt[6:0]);
      end
      CLEAR_ALL: begin
        memWe   = 1'b1;
        memAddr = clearCnt;
      end
      default: memWe = 1'b0;
    endcase
  end

  assign bus.wrReady = (state == IDLE);
  assign bus.busy    = (state != IDLE);

  // Cursor, scroll base and clear sweep counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cursorCol  <= 7'd0;
      cursorRow  <= 6'd0;
      scrollBase <= 6'd0;
      clearCnt   <= 13'd0;
      clearRow   <= 6'd0;
    end else if (state != IDLE) begin
      clearCnt <= (nextState == IDLE) ? 13'd0 : clearCnt + 13'd1;
    end else if (accept && isFormFeed) begin
      cursorCol  <= 7'd0;
      cursorRow  <= 6'd0;
      scrollBase <= 6'd0;
    end else if (accept) begin
      if (isPrint) begin
        cursorCol <= (cursorCol == LAST_COL) ? 7'd0 : cursorCol + 7'd1;
      end else if (bus.wrData == 8'h0D) begin
        cursorCol <= 7'd0;
      end else if ((bus.wrData == 8'h08) && (cursorCol != 7'd0)) begin
        cursorCol <= cursorCol - 7'd1;
      end else begin
        cursorCol <= cursorCol;
      end
      // At the bottom the top physical row becomes the new bottom row and is blanked.
      if (doNewline && !needScroll) begin
        cursorRow <= cursorRow + 6'd1;
      end else if (needScroll) begin
        clearRow   <= scrollBase;
        scrollBase <= (scrollBase == LAST_ROW) ? 6'd0 : scrollBase + 6'd1;
      end else begin
        cursorRow <= cursorRow;
      end
    end else begin
      clearCnt <= 13'd0;
    end
  end

  // Character memory write port.
  always_ff @(posedge clk) begin
    if (memWe && !reset) begin
      mem[memAddr] <= memData;
    end
  end

  assign rdCol = bus.characterPos[12:6];
  assign rdRow = bus.characterPos[5:0];

  // Zero-latency renderer lookup; off-screen positions read as a blank cell.
  always_comb begin
    rdCell = BLANK;
    if (({1'b0, rdCol} < 8'(COLS)) && ({1'b0, rdRow} < 7'(ROWS))) begin
      rdCell = mem[cellAddr(physRow(rdRow, scrollBase), rdCol)];
    end else begin
      rdCell = BLANK;
    end
  end

  assign bus.character = rdCell[13:6];
  assign bus.fgColor   = rdCell[5:3];
  assign bus.bgColor   = rdCell[2:0];
  assign bus.cursorCol = cursorCol;
  assign bus.cursorRow = cursorRow;

endmodule

// File: tb/tb_text_screen_buffer.sv
// Directed plus randomized bench for text_screen_buffer, checked against a logical-screen
// model that scrolls by physically shifting rows.
`timescale 1ns/1ps
module tb_text_screen_buffer;
  localparam int          COLS  = 80;
  localparam int          ROWS  = 60;
  localparam logic [13:0] BLANK = {8'h20, 3'b111, 3'b000};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  text_screen_buffer_if bus();

  text_screen_buffer #(
    .COLS(COLS), .ROWS(ROWS), .DEFAULT_FG(3'b111), .DEFAULT_BG(3'b000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [13:0] scr [ROWS][COLS];
  int mCol, mRow, expBusy;
  int nAsserts = 0;
  int nFails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void blankAll();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        scr[r][c] = BLANK;
  endfunction

  function automatic void newline();
    if (mRow < ROWS - 1) begin
      mRow++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = BLANK;
      expBusy = COLS;
    end
  endfunction

  function automatic void modelByte(input logic [7:0] d, input logic [2:0] fg, input logic [2:0] bg);
    expBusy = 0;
    if (d == 8'h0C) begin
      blankAll();
      mCol = 0; mRow = 0;
      expBusy = COLS * ROWS;
    end else if (d >= 8'h20 && d <= 8'h7F) begin
      scr[mRow][mCol] = {d, fg, bg};
      if (mCol < COLS - 1) mCol++;
      else begin mCol = 0; newline(); end
    end else if (d == 8'h0D) begin
      mCol = 0;
    end else if (d == 8'h0A) begin
      newline();
    end else if (d == 8'h08) begin
      if (mCol > 0) mCol--;
    end
  endfunction

  function automatic logic [13:0] expectCell(input int c, input int r);
    if (c >= COLS || r >= ROWS) return BLANK;
    return scr[r][c];
  endfunction

  // Counts cycles with wrReady low, starting at a negedge.
  task automatic countBusy(input string tag, input int exp);
    int n = 0;
    while (!bus.wrReady && n < 20000) begin
      chk({tag, ".busyFlag"}, bus.busy, 1);
      @(negedge clk);
      n++;
    end
    chk({tag, ".readyLowCycles"}, n, exp);
    chk({tag, ".busyIdle"}, bus.busy, 0);
  endtask

  task automatic sendByte(input logic [7:0] d, input logic [2:0] fg, input logic [2:0] bg, input bit waitClear);
    int n = 0;
    @(negedge clk);
    while (!bus.wrReady && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) chk("readyTimeout", 0, 1);
    bus.wrValid = 1'b1; bus.wrData = d; bus.wrFg = fg; bus.wrBg = bg;
    @(posedge clk); #1;
    bus.wrValid = 1'b0;
    modelByte(d, fg, bg);
    @(negedge clk);
    chk("cursorCol", bus.cursorCol, mCol);
    chk("cursorRow", bus.cursorRow, mRow);
    if (waitClear) countBusy("afterByte", expBusy);
  endtask

  task automatic readCell(input int c, input int r, input string tag);
    logic [6:0] cc;
    logic [5:0] rr;
    logic [13:0] e;
    cc = 7'(c); rr = 6'(r);
    @(negedge clk);
    bus.characterPos = {cc, rr};
    #1;
    e = expectCell(c, r);
    chk({tag, ".char"}, bus.character, e[13:6]);
    chk({tag, ".fg"}, bus.fgColor, e[5:3]);
    chk({tag, ".bg"}, bus.bgColor, e[2:0]);
  endtask

  task automatic screenCheck(input string tag);
    int bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        @(negedge clk);
        bus.characterPos = {7'(c), 6'(r)};
        #1;
        if ({bus.character, bus.fgColor, bus.bgColor} !== scr[r][c]) begin
          if (bad == 0) $display("%s first bad cell col %0d row %0d: got %h want %h", tag, c, r,
                                 {bus.character, bus.fgColor, bus.bgColor}, scr[r][c]);
          bad++;
        end
      end
    chk({tag, ".badCells"}, bad, 0);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    bus.wrValid = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, ".readyInReset"}, bus.wrReady, 0);
    reset = 1'b0;
    blankAll();
    mCol = 0; mRow = 0;
    chk({tag, ".cursorCol"}, bus.cursorCol, 0);
    chk({tag, ".cursorRow"}, bus.cursorRow, 0);
    countBusy(tag, COLS * ROWS);
  endtask

  initial begin
    logic [7:0] d;
    int sel;
    bus.wrValid = 1'b0; bus.wrData = 8'h00; bus.wrFg = 3'd0; bus.wrBg = 3'd0;
    bus.characterPos = 13'd0;

    // 1: reset clears the whole screen
    doReset("reset");
    screenCheck("resetScreen");

    // 2: one printable, then backspace without erase
    sendByte(8'h41, 3'd2, 3'd1, 1'b1);
    readCell(0, 0, "cellA");
    chk("cellA.const", bus.character, 8'h41);
    sendByte(8'h08, 3'd0, 3'd0, 1'b1);
    chk("bsCol", bus.cursorCol, 0);
    readCell(0, 0, "cellAfterBs");

    // 3: full row wraps; carriage return mid-row
    for (int i = 0; i < COLS; i++) sendByte(8'(8'h30 + i), 3'($urandom), 3'($urandom), 1'b1);
    chk("wrapRow", bus.cursorRow, 1);
    readCell(79, 0, "lastColCell");
    chk("lastCol.const", bus.character, 8'h7F);
    for (int i = 0; i < 5; i++) sendByte(8'($urandom_range(32, 127)), 3'($urandom), 3'($urandom), 1'b1);
    sendByte(8'h0D, 3'd0, 3'd0, 1'b1);
    chk("crRow", bus.cursorRow, 1);

    // 4: fill the screen then scroll once
    sendByte(8'h0C, 3'd0, 3'd0, 1'b1);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!(r == ROWS - 1 && c == COLS - 1))
          sendByte(8'(8'h30 + r), 3'($urandom), 3'($urandom), 1'b1);
    sendByte(8'h0A, 3'd0, 3'd0, 1'b1);
    readCell(5, 0, "scrollRow0");
    chk("scrollRow0.const", bus.character, 8'h31);
    readCell(5, 58, "scrollRow58");
    chk("scrollRow58.const", bus.character, 8'h6B);
    readCell(0, 59, "scrollRow59");
    chk("scrollRow59.const", bus.character, 8'h20);
    chk("scrollCursorRow", bus.cursorRow, 59);
    screenCheck("scrollScreen");

    // 5: off-screen reads and an ignored control byte
    readCell(85, 10, "oorCol");
    readCell(3, 61, "oorRow");
    chk("oorRow.fg", bus.fgColor, 3'd7);
    sendByte(8'h07, 3'd0, 3'd0, 1'b1);

    // random byte stream with random lookups
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 70) d = 8'($urandom_range(32, 127));
      else if (sel < 80) d = 8'h0A;
      else if (sel < 86) d = 8'h0D;
      else if (sel < 93) d = 8'h08;
      else if (sel < 97) d = 8'($urandom_range(128, 255));
      else d = 8'h1B;
      sendByte(d, 3'($urandom), 3'($urandom), 1'b1);
      readCell($urandom_range(0, 127), $urandom_range(0, 63), "randRead");
    end
    screenCheck("randomScreen");

    // 6: reset in the middle of a row clear
    for (int i = 0; i < ROWS; i++) sendByte(8'h0A, 3'd0, 3'd0, 1'b1);
    sendByte(8'h0A, 3'd0, 3'd0, 1'b0);
    chk("midClearBusy", bus.wrReady, 0);
    repeat (20) @(negedge clk);
    doReset("midClearReset");
    screenCheck("midClearScreen");

    // form feed on a busy screen
    for (int i = 0; i < 300; i++) sendByte(8'($urandom_range(32, 127)), 3'($urandom), 3'($urandom), 1'b1);
    sendByte(8'h0C, 3'd0, 3'd0, 1'b1);
    screenCheck("formFeedScreen");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
